// File: rtl/leaf_out_arbiter_if.sv
// Bundle of user-side, configuration, credit and BFT packet signals for leaf_out_arbiter.
// master = user/shell side driving requests, slave = the arbiter.
interface leaf_out_arbiter_if #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic                                  cfg_wr;
  logic [NUM_PORT_BITS-1:0]              cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dest_port;
  logic                                  credit_vld;
  logic [NUM_PORT_BITS-1:0]              credit_port;
  logic                                  resend;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

  modport master (
    output din_leaf_user2interface, vld_user2interface,
    output cfg_wr, cfg_port, cfg_dest_leaf, cfg_dest_port,
    output credit_vld, credit_port, resend,
    input  ack_interface2user, dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface,
    input  cfg_wr, cfg_port, cfg_dest_leaf, cfg_dest_port,
    input  credit_vld, credit_port, resend,
    output ack_interface2user, dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin packetiser merging user output ports into one registered BFT packet stream.
// Define LEAF_OUT_CREDIT_EN to enable per-port destination credit tracking and gating.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic             clk,
  input logic             reset,
  leaf_out_arbiter_if.slave bus
);
  localparam int IW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [NUM_LEAF_BITS-1:0] leaf_q  [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d  [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  payload [NUM_OUT_PORTS];
  logic [IW-1:0]            last_q, last_d;
  logic [NUM_OUT_PORTS-1:0] ack_q, ack_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_OUT_PORTS-1:0] credit_ok;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic                     grant_vld;
  logic [IW-1:0]            grant_idx;
  logic [IW-1:0]            cand;
  logic [IW-1:0]            cfg_idx;

  assign cfg_idx = bus.cfg_port[IW-1:0];

  // ack_q doubles as the "granted last cycle" mask that blocks a double send
  always_comb begin
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      payload[i]  = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      eligible[i] = bus.vld_user2interface[i] & ~ack_q[i] & ~bus.resend & credit_ok[i];
    end
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_OUT_PORTS);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    leaf_d  = leaf_q;
    dport_d = dport_q;
    addr_d  = addr_q;
    last_d  = last_q;
    ack_d   = '0;
    pkt_d   = pkt_q;
    pkt_d[PACKET_BITS-1] = 1'b0;
    if (bus.cfg_wr && (int'(bus.cfg_port) < NUM_OUT_PORTS)) begin
      leaf_d[cfg_idx]  = bus.cfg_dest_leaf;
      dport_d[cfg_idx] = bus.cfg_dest_port;
    end
    if (grant_vld) begin
      pkt_d = {1'b1, leaf_q[grant_idx], dport_q[grant_idx], addr_q[grant_idx],
               payload[grant_idx]};
      addr_d[grant_idx] = addr_q[grant_idx] + 1'b1;
      last_d            = grant_idx;
      ack_d[grant_idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]  <= '0;
        dport_q[i] <= NUM_PORT_BITS'(i);
        addr_q[i]  <= '0;
      end
      last_q <= IW'(NUM_OUT_PORTS - 1);
      ack_q  <= '0;
      pkt_q  <= '0;
    end else begin
      leaf_q  <= leaf_d;
      dport_q <= dport_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      pkt_q   <= pkt_d;
    end
  end

`ifdef LEAF_OUT_CREDIT_EN
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW-1:0] CREDIT_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CW:0]   CREDIT_INC = (CW+1)'(FREESPACE_UPDATE_SIZE);

  logic [CW-1:0] credit_q [NUM_OUT_PORTS];
  logic [CW-1:0] credit_d [NUM_OUT_PORTS];
  logic [CW:0]   credit_sum;

  // one extra bit of headroom so the return + grant sum can be saturated
  always_comb begin
    credit_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_ok[i] = (credit_q[i] != '0);
      credit_sum   = {1'b0, credit_q[i]};
      if (bus.credit_vld && (int'(bus.credit_port) == i))
        credit_sum = credit_sum + CREDIT_INC;
      if (grant_vld && (int'(grant_idx) == i))
        credit_sum = credit_sum - 1'b1;
      credit_d[i] = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) credit_q[i] <= CREDIT_MAX;
    end else begin
      credit_q <= credit_d;
    end
  end
`else
  logic credit_unused;
  assign credit_ok     = '1;
  assign credit_unused = ^{bus.credit_vld, bus.credit_port, (FREESPACE_UPDATE_SIZE != 0)};
`endif

  assign bus.dout_leaf_interface2bft = bus.resend ? '0 : pkt_q;
  assign bus.ack_interface2user      = bus.resend ? '0 : ack_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed self-checking bench for leaf_out_arbiter; credit expectations follow LEAF_OUT_CREDIT_EN.
module tb_leaf_out_arbiter;
  localparam int NP = 4, PB = 32, LB = 5, PTB = 4, AB = 7, PKB = 49;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  leaf_out_arbiter_if #(.NUM_OUT_PORTS(NP), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB),
                        .NUM_PORT_BITS(PTB), .PACKET_BITS(PKB)) bus_if ();

  leaf_out_arbiter #(.PACKET_BITS(PKB), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB),
                     .NUM_PORT_BITS(PTB), .NUM_ADDR_BITS(AB), .NUM_OUT_PORTS(NP),
                     .FREESPACE_UPDATE_SIZE(64))
    dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;

  function automatic logic [PKB-1:0] mk_pkt(input logic [LB-1:0] leaf, input logic [PTB-1:0] port,
                                            input logic [AB-1:0] addr, input logic [PB-1:0] pl);
    return {1'b1, leaf, port, addr, pl};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.din_leaf_user2interface = '0;
    bus_if.vld_user2interface      = '0;
    bus_if.cfg_wr                  = 1'b0;
    bus_if.cfg_port                = '0;
    bus_if.cfg_dest_leaf           = '0;
    bus_if.cfg_dest_port           = '0;
    bus_if.credit_vld              = 1'b0;
    bus_if.credit_port             = '0;
    bus_if.resend                  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [PB-1:0] data, input logic v);
    bus_if.din_leaf_user2interface[p*PB +: PB] = data;
    bus_if.vld_user2interface[p]               = v;
  endtask

  task automatic count_acks(input int p, input int ncyc, output int cnt, output logic [AB-1:0] first_addr);
    cnt = 0;
    first_addr = '0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (bus_if.ack_interface2user[p]) begin
        if (cnt == 0) first_addr = bus_if.dout_leaf_interface2bft[PB +: AB];
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== '0) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 0", bus_if.dout_leaf_interface2bft);
    end
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus_if.ack_interface2user);
    end
    reset = 1'b0;
    set_port(0, 32'h1234_5678, 1'b1);
    step();
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0001) begin
      n_fail++; $display("FAIL first_grant_after_reset: got %b expected 0001", bus_if.ack_interface2user);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== '0 || bus_if.ack_interface2user !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: got dout %h ack %b expected 0/0000",
                         bus_if.dout_leaf_interface2bft, bus_if.ack_interface2user);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    set_port(0, 32'hDEAD_BEEF, 1'b1);
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== mk_pkt(5'd0, 4'd0, 7'd0, 32'hDEAD_BEEF)) begin
      n_fail++; $display("FAIL basic_pkt: got %h expected %h", bus_if.dout_leaf_interface2bft,
                         mk_pkt(5'd0, 4'd0, 7'd0, 32'hDEAD_BEEF));
    end
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0001) begin
      n_fail++; $display("FAIL basic_ack: got %b expected 0001", bus_if.ack_interface2user);
    end
    set_port(0, 32'hDEAD_BEEF, 1'b0);
    step();
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0000 || bus_if.dout_leaf_interface2bft[PKB-1] !== 1'b0) begin
      n_fail++; $display("FAIL basic_single_pulse: got ack %b valid %b expected 0000/0",
                         bus_if.ack_interface2user, bus_if.dout_leaf_interface2bft[PKB-1]);
    end
  endtask

  task automatic test_round_robin();
    logic [PKB-1:0] exp_pkt;
    logic [NP-1:0]  exp_ack;
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 32'h1000_0000 + p, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      exp_ack = 4'b0001 << (c % 4);
      exp_pkt = mk_pkt(5'd0, 4'(c % 4), 7'(c / 4), 32'h1000_0000 + (c % 4));
      n_checks++;
      if (bus_if.ack_interface2user !== exp_ack) begin
        n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", c, bus_if.ack_interface2user, exp_ack);
      end
      n_checks++;
      if (bus_if.dout_leaf_interface2bft !== exp_pkt) begin
        n_fail++; $display("FAIL rr_pkt[%0d]: got %h expected %h", c, bus_if.dout_leaf_interface2bft, exp_pkt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_cfg();
    do_reset();
    bus_if.cfg_wr        = 1'b1;
    bus_if.cfg_port      = 4'd3;
    bus_if.cfg_dest_leaf = 5'd17;
    bus_if.cfg_dest_port = 4'd5;
    set_port(3, 32'hC0FF_EE03, 1'b1);
    step();
    bus_if.cfg_wr = 1'b0;
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== mk_pkt(5'd0, 4'd3, 7'd0, 32'hC0FF_EE03)) begin
      n_fail++; $display("FAIL cfg_same_cycle_old_entry: got %h expected %h", bus_if.dout_leaf_interface2bft,
                         mk_pkt(5'd0, 4'd3, 7'd0, 32'hC0FF_EE03));
    end
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft[PKB-1] !== 1'b0) begin
      n_fail++; $display("FAIL cfg_gap_valid: got %b expected 0", bus_if.dout_leaf_interface2bft[PKB-1]);
    end
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== mk_pkt(5'd17, 4'd5, 7'd1, 32'hC0FF_EE03)) begin
      n_fail++; $display("FAIL cfg_new_entry: got %h expected %h", bus_if.dout_leaf_interface2bft,
                         mk_pkt(5'd17, 4'd5, 7'd1, 32'hC0FF_EE03));
    end
    idle_inputs();
  endtask

  task automatic test_resend();
    do_reset();
    set_port(0, 32'hA5A5_0000, 1'b1);
    step();
    step();
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== mk_pkt(5'd0, 4'd0, 7'd1, 32'hA5A5_0000)) begin
      n_fail++; $display("FAIL resend_pre: got %h expected %h", bus_if.dout_leaf_interface2bft,
                         mk_pkt(5'd0, 4'd0, 7'd1, 32'hA5A5_0000));
    end
    bus_if.resend = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus_if.dout_leaf_interface2bft !== '0 || bus_if.ack_interface2user !== 4'b0000) begin
        n_fail++; $display("FAIL resend_hold[%0d]: got dout %h ack %b expected 0/0000", c,
                           bus_if.dout_leaf_interface2bft, bus_if.ack_interface2user);
      end
      if (c < 2) step();
    end
    step();
    bus_if.resend = 1'b0;
    step();
    n_checks++;
    if (bus_if.dout_leaf_interface2bft !== mk_pkt(5'd0, 4'd0, 7'd2, 32'hA5A5_0000) ||
        bus_if.ack_interface2user !== 4'b0001) begin
      n_fail++; $display("FAIL resend_resume: got dout %h ack %b expected %h/0001",
                         bus_if.dout_leaf_interface2bft, bus_if.ack_interface2user,
                         mk_pkt(5'd0, 4'd0, 7'd2, 32'hA5A5_0000));
    end
    idle_inputs();
  endtask

  task automatic test_credit();
    int            cnt, cnt2;
    logic [AB-1:0] last_addr, first_addr;
    do_reset();
    set_port(2, 32'h2222_0000, 1'b1);
    cnt = 0;
    last_addr = '0;
    for (int c = 0; c < 300 && cnt < 128; c++) begin
      step();
      if (bus_if.ack_interface2user[2]) begin
        last_addr = bus_if.dout_leaf_interface2bft[PB +: AB];
        cnt++;
      end
    end
    n_checks++;
    if (cnt != 128) begin
      n_fail++; $display("FAIL credit_first128: got %0d words expected 128", cnt);
    end
    n_checks++;
    if (last_addr !== 7'd127) begin
      n_fail++; $display("FAIL credit_addr127: got %0d expected 127", last_addr);
    end
    count_acks(2, 20, cnt2, first_addr);
`ifdef LEAF_OUT_CREDIT_EN
    n_checks++;
    if (cnt2 != 0) begin
      n_fail++; $display("FAIL credit_stall: got %0d words expected 0", cnt2);
    end
    bus_if.credit_vld  = 1'b1;
    bus_if.credit_port = 4'd2;
    step();
    bus_if.credit_vld = 1'b0;
    count_acks(2, 200, cnt2, first_addr);
    n_checks++;
    if (cnt2 != 64) begin
      n_fail++; $display("FAIL credit_refill: got %0d words expected 64", cnt2);
    end
`else
    n_checks++;
    if (cnt2 != 10) begin
      n_fail++; $display("FAIL credit_nogate: got %0d words expected 10", cnt2);
    end
`endif
    n_checks++;
    if (first_addr !== 7'd0) begin
      n_fail++; $display("FAIL credit_addr_wrap: got %0d expected 0", first_addr);
    end
    idle_inputs();
  endtask

  task automatic test_credit_sat();
    int            cnt;
    logic [AB-1:0] first_addr;
    do_reset();
    set_port(1, 32'h1111_0000, 1'b1);
    step();
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0010) begin
      n_fail++; $display("FAIL sat_first: got %b expected 0010", bus_if.ack_interface2user);
    end
    step();
    bus_if.credit_vld  = 1'b1;
    bus_if.credit_port = 4'd1;
    step();
    bus_if.credit_vld = 1'b0;
    n_checks++;
    if (bus_if.ack_interface2user !== 4'b0010) begin
      n_fail++; $display("FAIL sat_same_cycle_grant: got %b expected 0010", bus_if.ack_interface2user);
    end
    count_acks(1, 300, cnt, first_addr);
`ifdef LEAF_OUT_CREDIT_EN
    n_checks++;
    if (cnt != 128) begin
      n_fail++; $display("FAIL sat_credit128: got %0d words expected 128", cnt);
    end
`else
    n_checks++;
    if (cnt != 150) begin
      n_fail++; $display("FAIL sat_nogate: got %0d words expected 150", cnt);
    end
`endif
    n_checks++;
    if (first_addr !== 7'd2) begin
      n_fail++; $display("FAIL sat_addr: got %0d expected 2", first_addr);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_cfg();
    test_resend();
    test_credit();
    test_credit_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Parametrised output-side packetiser for a leaf: merges NUM_OUT_PORTS user output streams (valid/ack, 32-bit payload) into a single registered BFT packet stream using round-robin arbitration. Each user port has a programmable destination (leaf, port), a per-port wrapping address counter, and a credit counter that tracks destination free space. It replaces the fixed 4-output packing path in the leaf shell and runs in the BFT clock domain.

## Interface
- PACKET_BITS, 49, BFT packet width; equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, address field width; credit capacity = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 4, user output ports (1..16)
- FREESPACE_UPDATE_SIZE, 64, credits returned per update

- clk  in  1  BFT clock
- reset  in  1  asynchronous, active-high
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  port i payload at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2interface  in  NUM_OUT_PORTS  per-port valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port one-cycle accept pulse
- cfg_wr  in  1  destination table write strobe
- cfg_port  in  NUM_PORT_BITS  table entry written
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dest_port  in  NUM_PORT_BITS  destination port
- credit_vld  in  1  free-space update strobe
- credit_port  in  NUM_PORT_BITS  port receiving FREESPACE_UPDATE_SIZE credits
- resend  in  1  suppress output and arbitration
- dout_leaf_interface2bft  out  PACKET_BITS  packet; bit [PACKET_BITS-1] = valid

## Operation
- Packet fields, MSB first: valid | dest_leaf | dest_port | addr | payload.
- Eligible port i: vld[i]=1, credit[i]>0, not granted in previous cycle, resend=0.
- Round-robin: search starts at last_grant+1 modulo NUM_OUT_PORTS; at most one grant per cycle; pointer updates only on grant.
- On grant to port i: latch packet {1, leaf[i], port[i], addr[i], payload[i]}; addr[i] += 1 (wraps 2^NUM_ADDR_BITS-1 -> 0); credit[i] -= 1.
- Credit update: credit[credit_port] += FREESPACE_UPDATE_SIZE, saturating at 2^NUM_ADDR_BITS. credit_port >= NUM_OUT_PORTS ignored.
- Same-cycle grant and credit on one port: net +FREESPACE_UPDATE_SIZE-1, saturating.
- cfg_wr with cfg_port >= NUM_OUT_PORTS ignored; a write affects grants in the following cycle; a same-cycle grant uses the old entry.
- resend=1: output forced to 0 combinationally; no grants, no acks; counters hold; the registered packet is discarded.
- Reset: output 0, acks 0, last_grant = NUM_OUT_PORTS-1 (port 0 wins first), addr 0, credit 2^NUM_ADDR_BITS, table entry i = {leaf 0, port i}.

## Timing
- Grant decided combinationally in cycle N; dout valid and ack[i] both high in cycle N+1 (latency 1).
- User holds vld and data stable until it sees ack; it may present the next word in cycle N+2. The one-cycle ineligibility rule prevents a double send.
- Without a grant, the output valid bit returns to 0 the next cycle; the payload may hold stale data.
- Maximum throughput is one packet per cycle aggregate and one per two cycles per port.
- Async reset clears state immediately; the first grant can occur in the first cycle after deassertion.

## Configuration
- LEAF_OUT_CREDIT_EN defined: credit counters and credit gating are active as described.
- Undefined: credit logic is removed, credit_vld and credit_port are ignored, and credit>0 is treated as always true. Addresses still wrap.

## Test plan
- After reset, drive vld[0]=1 with payload 0xDEADBEEF -> next cycle the packet has valid=1, leaf 0, port 0, addr 0, payload 0xDEADBEEF, and ack[0]=1 for exactly one cycle.
- Hold all four ports valid for 8 cycles -> grants follow 0,1,2,3,0,1,2,3; each port's addr goes 0 then 1.
- With LEAF_OUT_CREDIT_EN, send 128 words on port 2 with no credit return -> the 129th word stalls; one credit_vld on port 2 -> 64 more words accepted; addr wraps 127 -> 0.
- In the same cycle as a port-1 grant with credit=0x7F, pulse credit_vld on port 1 -> credit saturates at 128 (not 190).
- Write cfg port 3 -> leaf 17, port 5, then send on port 3 -> packet dest fields are 17 and 5.
- Assert resend mid-stream for 3 cycles -> output is 0 and no acks; after release, traffic resumes with addr continuing from where it stopped.
